// File: rtl/issue_ctrl.sv
// Dual-issue dispatch: picks 0/1/2 head entries from the issue buffer, checks RAW
// hazards against the scoreboard and in-flight EX slots, and registers them into EX.
module issue_ctrl #(
    parameter int PAYLOAD_W = 128,
    parameter int NREG      = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [1:0]           is_valid,
    input  logic [PAYLOAD_W-1:0] a_payload,
    input  logic [PAYLOAD_W-1:0] b_payload,
    input  logic [4:0]           a_rd,
    input  logic [4:0]           b_rd,
    input  logic                 a_we,
    input  logic                 b_we,
    input  logic [4:0]           a_raddr1,
    input  logic [4:0]           a_raddr2,
    input  logic [4:0]           b_raddr1,
    input  logic [4:0]           b_raddr2,
    input  logic [1:0]           a_type,
    input  logic [1:0]           b_type,
    input  logic                 stall_DCache,
    input  logic                 stall_div,
    input  logic                 flush_BR,
    input  logic                 wb_clr0_en,
    input  logic                 wb_clr1_en,
    input  logic [4:0]           wb_clr0_addr,
    input  logic [4:0]           wb_clr1_addr,
    output logic [1:0]           o_usingNUM,
    output logic [1:0]           ex_valid,
    output logic [PAYLOAD_W-1:0] ex_a_payload,
    output logic [PAYLOAD_W-1:0] ex_b_payload,
    output logic [4:0]           ex_a_rd,
    output logic                 ex_a_we,
    output logic [1:0]           ex_a_type,
    output logic [4:0]           ex_b_rd,
    output logic                 ex_b_we,
    output logic [1:0]           ex_b_type,
    output logic [31:0]          cnt_dual,
    output logic [31:0]          cnt_single
);
    localparam logic [1:0] T_ALU = 2'd0;
    localparam logic [1:0] T_MEM = 2'd1;
    localparam logic [1:0] T_DIV = 2'd2;
    localparam logic [1:0] T_BR  = 2'd3;

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_stall;
    logic            w_long_a;
    logic            w_long_b;
    logic            w_issue_a;
    logic            w_issue_b;
    logic            w_intra_raw;

    assign w_stall = stall_DCache | stall_div;

    // EX slots holding a load/divide whose result is not yet available
    assign w_long_a = ex_valid[1] & ex_a_we & (ex_a_rd != 5'd0) &
                      ((ex_a_type == T_MEM) | (ex_a_type == T_DIV));
    assign w_long_b = ex_valid[0] & ex_b_we & (ex_b_rd != 5'd0) &
                      ((ex_b_type == T_MEM) | (ex_b_type == T_DIV));

    function automatic logic src_haz(input logic [4:0] r);
        return (r != 5'd0) &&
               (r_busy[r] || (w_long_a && (ex_a_rd == r)) || (w_long_b && (ex_b_rd == r)));
    endfunction

    assign w_intra_raw = a_we & (a_rd != 5'd0) & ((b_raddr1 == a_rd) | (b_raddr2 == a_rd));

    assign w_issue_a = is_valid[1] & ~w_stall & ~flush_BR &
                       ~src_haz(a_raddr1) & ~src_haz(a_raddr2);
    assign w_issue_b = w_issue_a & is_valid[0] & (b_type == T_ALU) & (a_type != T_BR) &
                       ~src_haz(b_raddr1) & ~src_haz(b_raddr2) & ~w_intra_raw;

    assign o_usingNUM = w_issue_b ? 2'd2 : (w_issue_a ? 2'd1 : 2'd0);

    // Clears first, sets last: a set on the same edge as a clear must win
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_clr0_en && (wb_clr0_addr != 5'd0)) w_busy_nxt[wb_clr0_addr] = 1'b0;
        if (wb_clr1_en && (wb_clr1_addr != 5'd0)) w_busy_nxt[wb_clr1_addr] = 1'b0;
        if (!flush_BR && !w_stall) begin
            if (w_long_a) w_busy_nxt[ex_a_rd] = 1'b1;
            if (w_long_b) w_busy_nxt[ex_b_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_busy       <= '0;
            ex_valid     <= 2'b00;
            ex_a_payload <= '0;
            ex_b_payload <= '0;
            ex_a_rd      <= 5'd0;
            ex_a_we      <= 1'b0;
            ex_a_type    <= T_ALU;
            ex_b_rd      <= 5'd0;
            ex_b_we      <= 1'b0;
            ex_b_type    <= T_ALU;
            cnt_dual     <= 32'd0;
            cnt_single   <= 32'd0;
        end else begin
            r_busy <= w_busy_nxt;
            if (flush_BR) begin
                ex_valid <= 2'b00;
            end else if (!w_stall) begin
                ex_valid     <= {w_issue_a, w_issue_b};
                ex_a_payload <= a_payload;
                ex_b_payload <= b_payload;
                ex_a_rd      <= a_rd;
                ex_a_we      <= a_we;
                ex_a_type    <= a_type;
                ex_b_rd      <= b_rd;
                ex_b_we      <= b_we;
                ex_b_type    <= b_type;
            end
            if (o_usingNUM == 2'd2) cnt_dual <= cnt_dual + 32'd1;
            if (o_usingNUM == 2'd1) cnt_single <= cnt_single + 32'd1;
        end
    end
endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios plus random traffic against a
// set/struct-based reference model of the dispatch rules.
module tb_issue_ctrl;
    localparam int PW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic [1:0]    is_valid;
    logic [PW-1:0] a_payload, b_payload;
    logic [4:0]    a_rd, b_rd, a_raddr1, a_raddr2, b_raddr1, b_raddr2;
    logic          a_we, b_we;
    logic [1:0]    a_type, b_type;
    logic          stall_DCache, stall_div, flush_BR;
    logic          wb_clr0_en, wb_clr1_en;
    logic [4:0]    wb_clr0_addr, wb_clr1_addr;
    logic [1:0]    o_usingNUM, ex_valid;
    logic [PW-1:0] ex_a_payload, ex_b_payload;
    logic [4:0]    ex_a_rd, ex_b_rd;
    logic          ex_a_we, ex_b_we;
    logic [1:0]    ex_a_type, ex_b_type;
    logic [31:0]   cnt_dual, cnt_single;

    issue_ctrl #(.PAYLOAD_W(PW), .NREG(32)) dut (
        .clk(clk), .rstn(rstn), .is_valid(is_valid),
        .a_payload(a_payload), .b_payload(b_payload),
        .a_rd(a_rd), .b_rd(b_rd), .a_we(a_we), .b_we(b_we),
        .a_raddr1(a_raddr1), .a_raddr2(a_raddr2), .b_raddr1(b_raddr1), .b_raddr2(b_raddr2),
        .a_type(a_type), .b_type(b_type),
        .stall_DCache(stall_DCache), .stall_div(stall_div), .flush_BR(flush_BR),
        .wb_clr0_en(wb_clr0_en), .wb_clr1_en(wb_clr1_en),
        .wb_clr0_addr(wb_clr0_addr), .wb_clr1_addr(wb_clr1_addr),
        .o_usingNUM(o_usingNUM), .ex_valid(ex_valid),
        .ex_a_payload(ex_a_payload), .ex_b_payload(ex_b_payload),
        .ex_a_rd(ex_a_rd), .ex_a_we(ex_a_we), .ex_a_type(ex_a_type),
        .ex_b_rd(ex_b_rd), .ex_b_we(ex_b_we), .ex_b_type(ex_b_type),
        .cnt_dual(cnt_dual), .cnt_single(cnt_single)
    );

    typedef struct packed {
        bit          v;
        bit          we;
        bit [4:0]    rd;
        bit [1:0]    ty;
        bit [PW-1:0] pl;
    } ex_t;

    int        tests = 0;
    int        fails = 0;
    ex_t       m_a, m_b;
    bit [31:0] m_busy;
    bit [31:0] m_dual, m_single;
    bit        m_fields_known;
    int        last_num;

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // A register is pending if the scoreboard says so or an EX load/divide targets it
    function automatic bit pending(ex_t e, bit [4:0] r);
        return e.v && e.we && (e.rd != 0) && (e.rd == r) && (e.ty == 2'd1 || e.ty == 2'd2);
    endfunction

    function automatic bit hz(bit [4:0] r);
        return (r != 0) && (m_busy[r] || pending(m_a, r) || pending(m_b, r));
    endfunction

    function automatic int model_num();
        bit st, ia, ib;
        st = stall_DCache | stall_div;
        ia = is_valid[1] && !st && !flush_BR && !hz(a_raddr1) && !hz(a_raddr2);
        ib = ia && is_valid[0] && (b_type == 2'd0) && (a_type != 2'd3) &&
             !hz(b_raddr1) && !hz(b_raddr2) &&
             !(a_we && a_rd != 0 && (b_raddr1 == a_rd || b_raddr2 == a_rd));
        return ib ? 2 : (ia ? 1 : 0);
    endfunction

    task automatic model_update(input int n);
        bit [31:0] setm, clrm;
        bit        st;
        st = stall_DCache | stall_div;
        if (rstn) begin
            m_a = '0; m_b = '0; m_busy = 0; m_dual = 0; m_single = 0; m_fields_known = 1;
        end else begin
            setm = 0; clrm = 0;
            if (!flush_BR && !st) begin
                if (m_a.v && m_a.we && m_a.rd != 0 && (m_a.ty == 1 || m_a.ty == 2)) setm[m_a.rd] = 1;
                if (m_b.v && m_b.we && m_b.rd != 0 && (m_b.ty == 1 || m_b.ty == 2)) setm[m_b.rd] = 1;
            end
            if (wb_clr0_en) clrm[wb_clr0_addr] = 1;
            if (wb_clr1_en) clrm[wb_clr1_addr] = 1;
            clrm[0] = 0;
            m_busy = (m_busy & ~clrm) | setm;
            if (flush_BR) begin
                m_a.v = 0; m_b.v = 0; m_fields_known = 0;
            end else if (!st) begin
                m_a = '{v: (n >= 1), we: a_we, rd: a_rd, ty: a_type, pl: a_payload};
                m_b = '{v: (n == 2), we: b_we, rd: b_rd, ty: b_type, pl: b_payload};
                m_fields_known = 1;
            end
            if (n == 2) m_dual++;
            if (n == 1) m_single++;
        end
    endtask

    task automatic check_regs();
        chk("ex_valid", ex_valid, {m_a.v, m_b.v});
        chk("cnt_dual", cnt_dual, m_dual);
        chk("cnt_single", cnt_single, m_single);
        if (m_fields_known) begin
            chk("ex_a_rd", ex_a_rd, m_a.rd);
            chk("ex_a_we", ex_a_we, m_a.we);
            chk("ex_a_type", ex_a_type, m_a.ty);
            chk("ex_a_payload", ex_a_payload, m_a.pl);
            chk("ex_b_rd", ex_b_rd, m_b.rd);
            chk("ex_b_we", ex_b_we, m_b.we);
            chk("ex_b_type", ex_b_type, m_b.ty);
            chk("ex_b_payload", ex_b_payload, m_b.pl);
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge
    task automatic cycle();
        int n;
        #1;
        n = model_num();
        last_num = int'(o_usingNUM);
        chk("usingNUM", o_usingNUM, n);
        @(posedge clk);
        model_update(n);
        @(negedge clk);
        check_regs();
    endtask

    task automatic clear_in();
        rstn = 0; is_valid = 0;
        a_payload = {$urandom, $urandom, $urandom, $urandom};
        b_payload = {$urandom, $urandom, $urandom, $urandom};
        a_rd = 0; b_rd = 0; a_we = 0; b_we = 0; a_type = 0; b_type = 0;
        a_raddr1 = 0; a_raddr2 = 0; b_raddr1 = 0; b_raddr2 = 0;
        stall_DCache = 0; stall_div = 0; flush_BR = 0;
        wb_clr0_en = 0; wb_clr1_en = 0; wb_clr0_addr = 0; wb_clr1_addr = 0;
    endtask

    initial begin
        bit [1:0] vsel;
        m_a = '0; m_b = '0; m_busy = 0; m_dual = 0; m_single = 0; m_fields_known = 0;
        clear_in();
        rstn = 1;
        @(negedge clk);
        cycle(); cycle();
        chk("rst_ex_valid", ex_valid, 2'b00);
        chk("rst_ex_a_rd", ex_a_rd, 5'd0);
        chk("rst_cnt_dual", cnt_dual, 32'd0);
        chk("rst_cnt_single", cnt_single, 32'd0);

        // two independent ALU ops
        clear_in(); is_valid = 2'b11;
        a_rd = 3; a_we = 1; a_raddr1 = 1; a_raddr2 = 2;
        b_rd = 4; b_we = 1; b_raddr1 = 5; b_raddr2 = 6;
        cycle();
        chk("dual_num", last_num, 2);
        chk("dual_ex_valid", ex_valid, 2'b11);
        chk("dual_ex_a_rd", ex_a_rd, 5'd3);
        chk("dual_ex_b_rd", ex_b_rd, 5'd4);
        chk("dual_cnt", cnt_dual, 32'd1);

        // intra-pair RAW
        clear_in(); is_valid = 2'b11; a_rd = 7; a_we = 1; b_raddr1 = 7; b_rd = 8; b_we = 1;
        cycle();
        chk("raw_num", last_num, 1);
        chk("raw_ex_valid", ex_valid, 2'b10);
        chk("raw_cnt_single", cnt_single, 32'd1);

        // load-use on r9
        clear_in(); is_valid = 2'b10; a_type = 1; a_rd = 9; a_we = 1;
        cycle();
        chk("ld_issue_num", last_num, 1);
        clear_in(); is_valid = 2'b10; a_raddr1 = 9; a_rd = 10; a_we = 1;
        cycle();
        chk("ld_use_ex_num", last_num, 0);
        cycle();
        chk("ld_use_busy_num", last_num, 0);
        wb_clr0_en = 1; wb_clr0_addr = 9;
        cycle();
        chk("ld_use_clr_cycle_num", last_num, 0);
        wb_clr0_en = 0;
        cycle();
        chk("ld_use_after_clr_num", last_num, 1);

        // backend stall
        clear_in(); is_valid = 2'b11; a_rd = 11; a_we = 1; a_raddr1 = 1; b_rd = 13; b_we = 1; b_raddr1 = 2;
        stall_div = 1;
        cycle();
        chk("stall_num", last_num, 0);
        chk("stall_ex_valid", ex_valid, 2'b10);
        chk("stall_ex_a_rd", ex_a_rd, 5'd10);
        chk("stall_cnt_single", cnt_single, 32'd3);
        stall_div = 0;
        cycle();
        chk("unstall_num", last_num, 2);
        chk("unstall_cnt_dual", cnt_dual, 32'd2);

        // flush squashes an EX divide to r12
        clear_in(); is_valid = 2'b10; a_type = 2; a_rd = 12; a_we = 1;
        cycle();
        clear_in(); is_valid = 2'b11; flush_BR = 1; a_raddr1 = 1; b_raddr1 = 2;
        cycle();
        chk("flush_num", last_num, 0);
        chk("flush_ex_valid", ex_valid, 2'b00);
        clear_in(); is_valid = 2'b10; a_raddr1 = 12;
        cycle();
        chk("flush_no_busy_num", last_num, 1);

        // same-edge set and clear of r5
        clear_in(); is_valid = 2'b10; a_type = 1; a_rd = 5; a_we = 1;
        cycle();
        clear_in(); wb_clr1_en = 1; wb_clr1_addr = 5;
        cycle();
        clear_in(); is_valid = 2'b10; a_raddr2 = 5;
        cycle();
        chk("set_wins_num", last_num, 0);
        clear_in(); is_valid = 2'b11; b_type = 1;
        cycle();
        chk("b_mem_num", last_num, 1);

        // random traffic with small register range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            clear_in();
            rstn = ($urandom_range(0, 99) < 2);
            vsel = 2'($urandom_range(0, 2));
            is_valid = (vsel == 0) ? 2'b00 : (vsel == 1) ? 2'b10 : 2'b11;
            a_rd = 5'($urandom_range(0, 7)); b_rd = 5'($urandom_range(0, 7));
            a_we = 1'($urandom); b_we = 1'($urandom);
            a_type = 2'($urandom); b_type = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
            a_raddr1 = 5'($urandom_range(0, 7)); a_raddr2 = 5'($urandom_range(0, 7));
            b_raddr1 = 5'($urandom_range(0, 7)); b_raddr2 = 5'($urandom_range(0, 7));
            stall_DCache = ($urandom_range(0, 99) < 6);
            stall_div = ($urandom_range(0, 99) < 5);
            flush_BR = ($urandom_range(0, 99) < 7);
            wb_clr0_en = ($urandom_range(0, 99) < 30); wb_clr0_addr = 5'($urandom_range(0, 7));
            wb_clr1_en = ($urandom_range(0, 99) < 30); wb_clr1_addr = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
